// File: rtl/esfa_pkg.sv
// ---------------------------------------------------------------------------
// esfa_pkg
// Shared constants for the ESFA cell-bus controller: cell-bus selector codes,
// host command op codes, response status codes and the sequencer state enum.
// ---------------------------------------------------------------------------
package esfa_pkg;

    // Cell-bus selector codes (3-bit, zero-extended onto the W-bit bus)
    localparam logic [2:0] SEL_UPDATE = 3'd0;  // write index/value into cell named by metadata
    localparam logic [2:0] SEL_LOOKUP = 3'd1;  // match index within array code in metadata
    localparam logic [2:0] SEL_RSVD2  = 3'd2;
    localparam logic [2:0] SEL_RSVD3  = 3'd3;
    localparam logic [2:0] SEL_RSVD4  = 3'd4;
    localparam logic [2:0] SEL_AVAIL  = 3'd5;  // markAvailableCell, read-only, doubles as idle
    localparam logic [2:0] SEL_ENRANK = 3'd6;  // report rank of cells holding array code
    localparam logic [2:0] SEL_DEBUG  = 3'd7;  // never driven by the sequencer

    // Host command op codes
    localparam logic [1:0] OP_UPDATE  = 2'd0;
    localparam logic [1:0] OP_LOOKUP  = 2'd1;
    localparam logic [1:0] OP_ENRANK  = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    // Response status codes
    localparam logic [1:0] RSP_OK   = 2'd0;  // OK / HIT
    localparam logic [1:0] RSP_MISS = 2'd1;
    localparam logic [1:0] RSP_FULL = 2'd2;
    localparam logic [1:0] RSP_ERR  = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        P1_WAIT   = 3'd1,
        P1_SAMPLE = 3'd2,
        P2_WAIT   = 3'd3,
        P2_SAMPLE = 3'd4,
        RESP      = 3'd5
    } seq_state_t;

endpackage

// File: rtl/esfa_hit_select.sv
// ---------------------------------------------------------------------------
// esfa_hit_select
// Combinational reduction of the per-cell reply vector.
//   i_hit        [NUM_CELLS]    per-cell bool
//   i_context    [NUM_CELLS*W]  per-cell context (rank), cell k at [k*W +: W]
//   o_low_handle [W]            lowest set bit of i_hit (0 when none)
//   o_max_handle [W]            hit with the largest rank, lowest handle on tie
//   o_any                       at least one hit
// ---------------------------------------------------------------------------
module esfa_hit_select #(
    parameter int NUM_CELLS = 8,
    parameter int W         = 8
) (
    input  logic [NUM_CELLS-1:0]   i_hit,
    input  logic [NUM_CELLS*W-1:0] i_context,
    output logic [W-1:0]           o_low_handle,
    output logic [W-1:0]           o_max_handle,
    output logic                   o_any
);

    logic [W-1:0] w_best_ctx;

    always_comb begin
        o_low_handle = '0;
        o_max_handle = '0;
        o_any        = 1'b0;
        w_best_ctx   = '0;
        // Scan downwards so the last assignment is the lowest set bit.
        for (int k = NUM_CELLS - 1; k >= 0; k--) begin
            if (i_hit[k]) o_low_handle = W'(k);
        end
        // Strict '>' on an ascending scan keeps the lowest handle on equal ranks.
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (i_hit[k] && (!o_any || (i_context[k*W +: W] > w_best_ctx))) begin
                w_best_ctx   = i_context[k*W +: W];
                o_max_handle = W'(k);
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/esfa_cell_sequencer.sv
// ---------------------------------------------------------------------------
// esfa_cell_sequencer
// Command-level controller and sole driver of the shared ESFA cell bus.
// Runs each host command as a fixed sequence of bus operations and reduces
// the per-cell replies to a single response.
//   clk, reset                 clock, synchronous active-low reset
//   cmd_valid/ready/op/array/index/value   host command handshake
//   rsp_valid/ready/status/data            host response handshake
//   cell_selector/index/value/metadata/is_meta   registered broadcast bus
//   cell_bool/result/context   per-cell replies, cell k at [k*W +: W]
// ---------------------------------------------------------------------------
module esfa_cell_sequencer
    import esfa_pkg::*;
#(
    parameter int NUM_CELLS = 8,
    parameter int W         = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [W-1:0]           cmd_array,
    input  logic [W-1:0]           cmd_index,
    input  logic [W-1:0]           cmd_value,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_status,
    output logic [W-1:0]           rsp_data,
    output logic [W-1:0]           cell_selector,
    output logic [W-1:0]           cell_index,
    output logic [W-1:0]           cell_value,
    output logic [W-1:0]           cell_metadata,
    output logic                   cell_is_meta,
    input  logic [NUM_CELLS-1:0]   cell_bool,
    input  logic [NUM_CELLS*W-1:0] cell_result,
    input  logic [NUM_CELLS*W-1:0] cell_context
);

    seq_state_t   r_state;
    logic [1:0]   r_op;
    logic [W-1:0] r_index, r_value, r_handle;
    logic         r_cmd_ready, r_rsp_valid;
    logic [1:0]   r_rsp_status;
    logic [W-1:0] r_rsp_data;
    logic [W-1:0] r_sel, r_bus_index, r_bus_value, r_bus_meta;
    logic         r_is_meta;

    logic [W-1:0] w_low_handle, w_max_handle;
    logic         w_any;
    logic [W-1:0] w_max_result, w_low_context;
    logic         w_h_bool;
    logic         w_done;
    logic [1:0]   w_done_status;
    logic [W-1:0] w_done_data;

    esfa_hit_select #(.NUM_CELLS(NUM_CELLS), .W(W)) u_hit (
        .i_hit        (cell_bool),
        .i_context    (cell_context),
        .o_low_handle (w_low_handle),
        .o_max_handle (w_max_handle),
        .o_any        (w_any)
    );

    // Per-cell muxes keyed by handle: winner's result, lowest hit's context,
    // and the phase-2 bool of the cell allocated in phase 1.
    always_comb begin
        w_max_result  = '0;
        w_low_context = '0;
        w_h_bool      = 1'b0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (w_max_handle == W'(k)) w_max_result  = cell_result[k*W +: W];
            if (w_low_handle == W'(k)) w_low_context = cell_context[k*W +: W];
            if (r_handle == W'(k))     w_h_bool      = cell_bool[k];
        end
    end

    // Every way a command finishes: decides entry to RESP and its payload.
    always_comb begin
        w_done        = 1'b0;
        w_done_status = RSP_OK;
        w_done_data   = '0;
        case (r_state)
            P1_WAIT: begin
                if (r_op == OP_ILLEGAL) begin
                    w_done        = 1'b1;
                    w_done_status = RSP_ERR;
                end
            end
            P1_SAMPLE: begin
                case (r_op)
                    OP_LOOKUP: begin
                        w_done        = 1'b1;
                        w_done_status = w_any ? RSP_OK : RSP_MISS;
                        w_done_data   = w_any ? w_max_result : '0;
                    end
                    OP_ENRANK: begin
                        w_done        = 1'b1;
                        w_done_status = w_any ? RSP_OK : RSP_MISS;
                        w_done_data   = w_any ? w_low_context : '0;
                    end
                    default: begin
                        // UPDATE: only finishes here when no cell is free
                        if (!w_any) begin
                            w_done        = 1'b1;
                            w_done_status = RSP_FULL;
                        end
                    end
                endcase
            end
            P2_SAMPLE: begin
                w_done        = 1'b1;
                w_done_status = w_h_bool ? RSP_OK : RSP_ERR;
                w_done_data   = r_handle;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= RSP_OK;
            r_rsp_data   <= '0;
            r_sel        <= W'(SEL_AVAIL);
            r_bus_index  <= '0;
            r_bus_value  <= '0;
            r_bus_meta   <= '0;
            r_is_meta    <= 1'b0;
            r_op         <= OP_UPDATE;
            r_index      <= '0;
            r_value      <= '0;
            r_handle     <= '0;
        end else if (w_done) begin
            // Response and bus idle pattern land on the same edge.
            r_state      <= RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= w_done_status;
            r_rsp_data   <= w_done_data;
            r_sel        <= W'(SEL_AVAIL);
            r_bus_index  <= '0;
            r_bus_value  <= '0;
            r_bus_meta   <= '0;
            r_is_meta    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= cmd_op;
                        r_index     <= cmd_index;
                        r_value     <= cmd_value;
                        r_cmd_ready <= 1'b0;
                        r_state     <= P1_WAIT;
                        case (cmd_op)
                            OP_UPDATE: begin
                                r_sel     <= W'(SEL_AVAIL);
                                r_is_meta <= 1'b0;
                            end
                            OP_LOOKUP: begin
                                r_sel       <= W'(SEL_LOOKUP);
                                r_bus_index <= cmd_index;
                                r_bus_meta  <= cmd_array;
                                r_is_meta   <= 1'b1;
                            end
                            OP_ENRANK: begin
                                r_sel      <= W'(SEL_ENRANK);
                                r_bus_meta <= cmd_array;
                                r_is_meta  <= 1'b1;
                            end
                            default: ;  // illegal op leaves the bus idle
                        endcase
                    end
                end
                P1_WAIT: r_state <= P1_SAMPLE;
                P1_SAMPLE: begin
                    // Only an UPDATE with a free cell gets here: write into it.
                    r_handle    <= w_low_handle;
                    r_sel       <= W'(SEL_UPDATE);
                    r_bus_meta  <= w_low_handle;
                    r_is_meta   <= 1'b1;
                    r_bus_index <= r_index;
                    r_bus_value <= r_value;
                    r_state     <= P2_WAIT;
                end
                P2_WAIT: r_state <= P2_SAMPLE;
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_status    = r_rsp_status;
    assign rsp_data      = r_rsp_data;
    assign cell_selector = r_sel;
    assign cell_index    = r_bus_index;
    assign cell_value    = r_bus_value;
    assign cell_metadata = r_bus_meta;
    assign cell_is_meta  = r_is_meta;

endmodule

// File: tb/tb_esfa_cell_sequencer.sv
// Bench for esfa_cell_sequencer: a registered behavioural cell array reacts
// to the bus, an override path injects hand-picked replies, and a reference
// table of cell contents predicts every response.
module tb_esfa_cell_sequencer;
    import esfa_pkg::*;

    localparam int NC = 8;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_op = 2'd0;
    logic [W-1:0]    cmd_array = '0, cmd_index = '0, cmd_value = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_status;
    logic [W-1:0]    rsp_data;
    logic [W-1:0]    cell_selector, cell_index, cell_value, cell_metadata;
    logic            cell_is_meta;
    logic [NC-1:0]   cell_bool;
    logic [NC*W-1:0] cell_result, cell_context;

    int n_vec = 0;
    int n_err = 0;
    int bad_sel = 0;
    logic saw_sel0;

    esfa_cell_sequencer #(.NUM_CELLS(NC), .W(W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_array(cmd_array), .cmd_index(cmd_index), .cmd_value(cmd_value),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_data(rsp_data),
        .cell_selector(cell_selector), .cell_index(cell_index),
        .cell_value(cell_value), .cell_metadata(cell_metadata),
        .cell_is_meta(cell_is_meta), .cell_bool(cell_bool),
        .cell_result(cell_result), .cell_context(cell_context)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural cell array (environment) ----------------
    logic         cm_occ  [NC];
    logic [W-1:0] cm_idx  [NC];
    logic [W-1:0] cm_val  [NC];
    logic [W-1:0] cm_rank [NC];
    logic [W-1:0] cm_res  [NC];
    logic [W-1:0] cm_ctx  [NC];
    logic [NC-1:0] cm_bool;
    logic [W-1:0] cm_cnt;
    logic         cm_last0;

    always @(posedge clk) begin
        if (!reset) begin
            cm_bool  <= '0;
            cm_cnt   <= 8'd1;
            cm_last0 <= 1'b0;
            for (int k = 0; k < NC; k++) begin
                cm_occ[k] <= 1'b0;
                cm_res[k] <= '0;
                cm_ctx[k] <= '0;
            end
        end else begin
            cm_last0 <= (cell_selector == 8'd0);
            // one rank per write burst, advanced once the write selector leaves
            if (cell_selector != 8'd0 && cm_last0) cm_cnt <= cm_cnt + 8'd1;
            for (int k = 0; k < NC; k++) begin
                cm_bool[k] <= 1'b0;
                case (cell_selector)
                    8'd5: cm_bool[k] <= !cm_occ[k];
                    8'd0: if (cell_is_meta && cell_metadata == W'(k)) begin
                        cm_occ[k]  <= 1'b1;
                        cm_idx[k]  <= cell_index;
                        cm_val[k]  <= cell_value;
                        cm_rank[k] <= cm_cnt;
                        cm_bool[k] <= 1'b1;
                    end
                    8'd1: begin
                        cm_bool[k] <= cm_occ[k] && (cm_idx[k] == cell_index);
                        cm_res[k]  <= cm_val[k];
                        cm_ctx[k]  <= cm_rank[k];
                    end
                    8'd6: begin
                        cm_bool[k] <= cm_occ[k];
                        cm_ctx[k]  <= cm_rank[k];
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- override path ----------------
    logic          force_en = 1'b0;
    logic [NC-1:0] f_bool = '0, f_bool2 = '0;  // f_bool2 applies while bus sel==0
    logic [W-1:0]  f_res [NC];
    logic [W-1:0]  f_ctx [NC];

    always_comb begin
        cell_result  = '0;
        cell_context = '0;
        for (int k = 0; k < NC; k++) begin
            cell_result[k*W +: W]  = force_en ? f_res[k] : cm_res[k];
            cell_context[k*W +: W] = force_en ? f_ctx[k] : cm_ctx[k];
        end
        cell_bool = force_en ? ((cell_selector == 8'd0) ? f_bool2 : f_bool) : cm_bool;
    end

    always @(negedge clk) begin
        if (reset && (cell_selector == 8'd3 || cell_selector == 8'd4 || cell_selector >= 8'd7))
            bad_sel++;
    end

    // ---------------- reference table ----------------
    logic         ref_occ  [NC];
    logic [W-1:0] ref_idx  [NC];
    logic [W-1:0] ref_val  [NC];
    logic [W-1:0] ref_rank [NC];
    logic [W-1:0] ref_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic predict(input logic [1:0] op, input logic [W-1:0] idx, input logic [W-1:0] val,
                           output logic [1:0] st, output logic [W-1:0] d, output int lat);
        int h;
        st = RSP_MISS; d = '0; lat = 2; h = -1;
        case (op)
            OP_UPDATE: begin
                for (int k = 0; k < NC; k++) if (h < 0 && !ref_occ[k]) h = k;
                if (h < 0) st = RSP_FULL;
                else begin
                    st = RSP_OK; d = W'(h); lat = 4;
                    ref_occ[h] = 1'b1; ref_idx[h] = idx; ref_val[h] = val;
                    ref_rank[h] = ref_cnt; ref_cnt++;
                end
            end
            OP_LOOKUP: begin
                // most recently written matching entry wins
                for (int k = 0; k < NC; k++)
                    if (ref_occ[k] && ref_idx[k] == idx && (h < 0 || ref_rank[k] > ref_rank[h])) h = k;
                if (h >= 0) begin st = RSP_OK; d = ref_val[h]; end
            end
            OP_ENRANK: begin
                for (int k = 0; k < NC; k++) if (h < 0 && ref_occ[k]) h = k;
                if (h >= 0) begin st = RSP_OK; d = ref_rank[h]; end
            end
            default: begin st = RSP_ERR; lat = 1; end
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < NC; k++) ref_occ[k] = 1'b0;
        ref_cnt = 8'd1;
        @(negedge clk);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] arr, input logic [W-1:0] idx,
                           input logic [W-1:0] val, input int hold,
                           input logic [1:0] e_st, input logic [W-1:0] e_d, input int e_lat);
        int lat, guard;
        logic got;
        guard = 0;
        while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_op = op; cmd_array = arr; cmd_index = idx; cmd_value = val; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        got = 1'b0; lat = 0; saw_sel0 = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            if (cell_selector == 8'd0) saw_sel0 = 1'b1;
            if (op == OP_ILLEGAL) begin
                chk("illegal_bus_sel", cell_selector, 5);
                chk("illegal_bus_meta", cell_is_meta, 0);
            end
            if (rsp_valid) got = 1'b1;
            else begin @(posedge clk); lat++; end
        end
        chk("rsp_seen", got, 1);
        chk("latency", lat, e_lat);
        chk("status", rsp_status, e_st);
        chk("data", rsp_data, e_d);
        chk("resp_bus_sel", cell_selector, 5);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_status", rsp_status, e_st);
            chk("hold_data", rsp_data, e_d);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("valid_drop", rsp_valid, 0);
        chk("ready_back", cmd_ready, 1);
        chk("idle_sel", cell_selector, 5);
        chk("idle_meta", cell_is_meta, 0);
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [W-1:0] idx, input logic [W-1:0] val,
                             input int hold);
        logic [1:0] st; logic [W-1:0] d; int lat;
        predict(op, idx, val, st, d, lat);
        run_cmd(op, W'($urandom), idx, val, hold, st, d, lat);
    endtask

    task automatic forced_lookup(input logic [1:0] op);
        logic [W-1:0] m, d;
        int w;
        m = '0; w = -1; d = '0;
        for (int k = 0; k < NC; k++) if (f_bool[k] && f_ctx[k] > m) m = f_ctx[k];
        if (op == OP_LOOKUP) begin
            for (int k = 0; k < NC; k++) if (w < 0 && f_bool[k] && f_ctx[k] == m) w = k;
            if (w >= 0) d = f_res[w];
        end else begin
            for (int k = 0; k < NC; k++) if (w < 0 && f_bool[k]) w = k;
            if (w >= 0) d = f_ctx[w];
        end
        run_cmd(op, 8'd0, 8'd0, 8'd0, 0, (w >= 0) ? RSP_OK : RSP_MISS, d, 2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < NC; k++) begin f_res[k] = '0; f_ctx[k] = '0; end
        do_reset();

        // reset state
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_status", rsp_status, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_sel", cell_selector, 5);
        chk("rst_index", cell_index, 0);
        chk("rst_value", cell_value, 0);
        chk("rst_meta", cell_metadata, 0);
        chk("rst_is_meta", cell_is_meta, 0);

        // first insert, lookups, enrank
        model_cmd(OP_UPDATE, 8'd3, 8'h55, 0);
        chk("cell0_index", cm_idx[0], 3);
        chk("cell0_value", cm_val[0], 8'h55);
        model_cmd(OP_LOOKUP, 8'd3, 8'd0, 0);
        model_cmd(OP_LOOKUP, 8'd9, 8'd0, 1);
        model_cmd(OP_ENRANK, 8'd0, 8'd0, 0);

        // fill the remaining cells, then overflow
        for (int i = 0; i < NC - 1; i++)
            model_cmd(OP_UPDATE, W'($urandom_range(0, 7)), W'($urandom), $urandom_range(0, 2));
        model_cmd(OP_UPDATE, 8'd4, 8'hAA, 0);
        chk("full_no_sel0", saw_sel0, 0);

        // illegal op with a long-held response
        model_cmd(OP_ILLEGAL, 8'd1, 8'd2, 5);

        // random reads over the full table
        for (int i = 0; i < 30; i++)
            model_cmd(2'($urandom_range(1, 3)), W'($urandom_range(0, 9)), 8'd0, $urandom_range(0, 2));

        // random mixed traffic from empty
        do_reset();
        for (int i = 0; i < 60; i++)
            model_cmd(2'($urandom_range(0, 3)), W'($urandom_range(0, 9)), W'($urandom), $urandom_range(0, 2));

        // reset while an UPDATE sits in phase 2
        do_reset();
        cmd_op = OP_UPDATE; cmd_index = 8'd7; cmd_value = 8'h77; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_sel0_seen", cell_selector, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_sel", cell_selector, 5);
        chk("midrst_meta", cell_is_meta, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        repeat (4) @(negedge clk);
        chk("midrst_no_rsp", rsp_valid, 0);
        for (int k = 0; k < NC; k++) ref_occ[k] = 1'b0;
        ref_cnt = 8'd1;
        model_cmd(OP_UPDATE, 8'd2, 8'h22, 0);

        // injected replies
        force_en = 1'b1;
        for (int k = 0; k < NC; k++) f_res[k] = 8'hA0 + W'(k);
        f_bool = 8'b0010_0100; f_ctx[2] = 8'd1; f_ctx[5] = 8'd3;
        run_cmd(OP_LOOKUP, 8'd0, 8'd3, 8'd0, 0, RSP_OK, 8'hA5, 2);
        f_ctx[5] = 8'd1;
        run_cmd(OP_LOOKUP, 8'd0, 8'd3, 8'd0, 0, RSP_OK, 8'hA2, 2);
        f_ctx[2] = 8'h7F; f_ctx[5] = 8'h80;
        run_cmd(OP_LOOKUP, 8'd0, 8'd3, 8'd0, 0, RSP_OK, 8'hA5, 2);
        run_cmd(OP_ENRANK, 8'd0, 8'd0, 8'd0, 0, RSP_OK, 8'h7F, 2);
        f_bool2 = 8'b0000_0100;
        run_cmd(OP_UPDATE, 8'd0, 8'd1, 8'h11, 0, RSP_OK, 8'd2, 4);
        f_bool2 = 8'b0010_0000;
        run_cmd(OP_UPDATE, 8'd0, 8'd1, 8'h11, 0, RSP_ERR, 8'd2, 4);
        f_bool = '0;
        run_cmd(OP_UPDATE, 8'd0, 8'd1, 8'h11, 0, RSP_FULL, 8'd0, 2);
        chk("forced_full_no_sel0", saw_sel0, 0);
        for (int i = 0; i < 30; i++) begin
            f_bool = NC'($urandom);
            for (int k = 0; k < NC; k++) begin
                f_ctx[k] = W'($urandom_range(0, 3)) << 6;
                f_res[k] = W'($urandom);
            end
            forced_lookup((i % 3 == 0) ? OP_ENRANK : OP_LOOKUP);
        end
        force_en = 1'b0;

        chk("bad_selectors", bad_sel, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
